// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the Game-of-Life generation controller
//
// Purpose : FSM state encoding, memory write-flag codes and the dead-cell byte.
// Ports   : none (package).
package life_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    COMMIT,
    DONE
  } state_e;

  localparam logic [1:0] WF_NONE    = 2'b00;
  localparam logic [1:0] WF_WRITE   = 2'b01;
  localparam logic [1:0] WF_REPLACE = 2'b10;

  localparam logic [7:0] CELL_DEAD  = 8'h00;
  localparam logic [5:0] LAST_PIXEL = 6'd63;

endpackage

// File: rtl/life_gen_controller_if.sv
// rtl/life_gen_controller_if.sv - cell memory bus between controller and double-buffered grid
//
// Purpose : groups the pixel address, write data/flag and the three registered row lines.
// Ports   : pixel           - cell address {row, col}
//           new_pixel_value - byte written on WRITE
//           write_flag      - 00 none, 01 WRITE, 10 REPLACE
//           previous_line / current_line / next_line - rows row-1, row, row+1 (wrapped),
//           registered by the memory one cycle after pixel is presented
interface life_gen_controller_if;

  logic [5:0]  pixel;
  logic [7:0]  new_pixel_value;
  logic [1:0]  write_flag;
  logic [63:0] previous_line;
  logic [63:0] current_line;
  logic [63:0] next_line;

  modport master (
    output pixel,
    output new_pixel_value,
    output write_flag,
    input  previous_line,
    input  current_line,
    input  next_line
  );

  modport slave (
    input  pixel,
    input  new_pixel_value,
    input  write_flag,
    output previous_line,
    output current_line,
    output next_line
  );

endinterface

// File: rtl/life_rule.sv
// rtl/life_rule.sv - combinational Game-of-Life rule for one cell
//
// Purpose : counts the eight toroidal neighbours of column col_i and applies B3/S23.
// Ports   : previous_line_i, current_line_i, next_line_i - row lines (row wrap done by memory)
//           col_i       - column of the cell under evaluation
//           next_byte_o - ALIVE_VAL if the cell lives next generation, else CELL_DEAD
module life_rule
  import life_pkg::*;
#(
  parameter logic [7:0] ALIVE_VAL = 8'hFF
) (
  input  logic [63:0] previous_line_i,
  input  logic [63:0] current_line_i,
  input  logic [63:0] next_line_i,
  input  logic [2:0]  col_i,
  output logic [7:0]  next_byte_o
);

  logic [2:0] col_m1;
  logic [2:0] col_p1;
  logic [3:0] n;
  logic       alive;

  // 3-bit arithmetic gives the column wrap for free (0-1 -> 7, 7+1 -> 0).
  assign col_m1 = col_i - 3'd1;
  assign col_p1 = col_i + 3'd1;

  function automatic logic [3:0] live(input logic [63:0] line, input logic [2:0] c);
    return {3'b000, |line[{c, 3'b000} +: 8]};
  endfunction

  assign alive = |current_line_i[{col_i, 3'b000} +: 8];

  assign n = live(previous_line_i, col_m1) + live(previous_line_i, col_i) +
             live(previous_line_i, col_p1) + live(current_line_i, col_m1) +
             live(current_line_i, col_p1)  + live(next_line_i, col_m1) +
             live(next_line_i, col_i)      + live(next_line_i, col_p1);

  always_comb begin
    next_byte_o = CELL_DEAD;
    if ((alive && (n == 4'd2 || n == 4'd3)) || (!alive && n == 4'd3)) begin
      next_byte_o = ALIVE_VAL;
    end
  end

endmodule

// File: rtl/life_gen_controller.sv
// rtl/life_gen_controller.sv - sequences one Game-of-Life generation over an 8x8 grid
//
// Purpose : walks all 64 cells (READ then EVAL per cell), writes each next state to the
//           write buffer, then issues a single REPLACE to publish the generation.
//           Generations start on step_i or, while run_i is high, every GEN_PERIOD idle cycles.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           run_i        - level, enables the auto-generation timer
//           step_i       - pulse, starts one generation when idle
//           mem          - cell memory bus (master side)
//           busy_o       - high from READ through DONE
//           gen_done_o   - one-cycle pulse in DONE
//           gen_count_o  - completed generations, wraps at 16 bits
module life_gen_controller
  import life_pkg::*;
#(
  parameter int unsigned GEN_PERIOD = 1000000,
  parameter logic [7:0]  ALIVE_VAL  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_i,
  input  logic                   step_i,
  life_gen_controller_if.master  mem,
  output logic                   busy_o,
  output logic                   gen_done_o,
  output logic [15:0]            gen_count_o
);

  state_e      state_q, state_d;
  logic [5:0]  pixel_q, pixel_d;
  logic [31:0] tick_q, tick_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        start;
  logic [7:0]  rule_byte;

  life_rule #(
    .ALIVE_VAL(ALIVE_VAL)
  ) u_rule (
    .previous_line_i(mem.previous_line),
    .current_line_i (mem.current_line),
    .next_line_i    (mem.next_line),
    .col_i          (pixel_q[2:0]),
    .next_byte_o    (rule_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pixel_q     <= '0;
      tick_q      <= '0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pixel_q     <= pixel_d;
      tick_q      <= tick_d;
      gen_count_q <= gen_count_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pixel_d             = pixel_q;
    tick_d              = tick_q;
    gen_count_d         = gen_count_q;
    start               = 1'b0;
    mem.write_flag      = WF_NONE;
    mem.new_pixel_value = CELL_DEAD;
    busy_o              = 1'b1;
    gen_done_o          = 1'b0;

    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        // A step and a timer expiry in the same cycle merge into one start.
        start  = step_i | (run_i & (tick_q == GEN_PERIOD - 1));
        if (start) begin
          state_d = READ;
          pixel_d = '0;
          tick_d  = '0;
        end else if (run_i) begin
          tick_d = tick_q + 32'd1;
        end else begin
          tick_d = '0;
        end
      end
      // Memory registers the three lines for pixel_q at the end of this cycle.
      READ: state_d = EVAL;
      EVAL: begin
        mem.write_flag      = WF_WRITE;
        mem.new_pixel_value = rule_byte;
        if (pixel_q == LAST_PIXEL) begin
          state_d = COMMIT;
        end else begin
          pixel_d = pixel_q + 6'd1;
          state_d = READ;
        end
      end
      COMMIT: begin
        mem.write_flag = WF_REPLACE;
        state_d        = DONE;
      end
      DONE: begin
        gen_done_o  = 1'b1;
        gen_count_d = gen_count_q + 16'd1;
        pixel_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.pixel   = pixel_q;
  assign gen_count_o = gen_count_q;

endmodule

// File: doc/life_gen_controller.md
Name: life_gen_controller

Overview:
- Sequences one Game-of-Life generation over the 8x8 double-buffered cell memory (64 cells, 8-bit each, 64-bit row lines).
- Walks all 64 pixels and computes each cell's next state from the registered previous/current/next lines.
- Writes each result into the write buffer (write_flag WRITE), then issues one REPLACE to publish the generation.
- Generations are paced by a free-running period timer (run) or triggered singly (step).

Parameters:
GEN_PERIOD, 1000000, IDLE cycles between auto-generations while run=1; legal range >= 2
ALIVE_VAL, 8'hFF, byte written for a live cell; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; auto-generate every GEN_PERIOD idle cycles
step  in  1  one-cycle pulse; start one generation if idle
previous_line  in  64  memory row (row-1, wrapped), valid the cycle after pixel is presented
current_line  in  64  memory row (row), same timing as previous_line
next_line  in  64  memory row (row+1, wrapped), same timing as previous_line
pixel  out  6  cell address {row[2:0], col[2:0]}; cell byte is line[8*col+7 -: 8]
new_pixel_value  out  8  next-state byte; ALIVE_VAL or 8'h00
write_flag  out  2  2'b00 none, 2'b01 WRITE, 2'b10 REPLACE
busy  out  1  high from READ through DONE
gen_done  out  1  one-cycle pulse in DONE
gen_count  out  16  completed generations; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, pixel 0, write_flag 00, new_pixel_value 0, busy 0, gen_done 0, gen_count 0, tick 0. All outputs take these values immediately.
- Reset mid-generation: no REPLACE is issued, so the published grid is unchanged. A partially written write buffer is harmless because every cell is rewritten next generation.
- States: IDLE, READ, EVAL, COMMIT, DONE.
- IDLE:
  - tick counts while run=1 and clears when run=0.
  - start = step | (run & tick==GEN_PERIOD-1).
  - start -> READ with pixel=0 and tick cleared.
  - step and timer expiry in the same cycle produce a single start.
- READ: present pixel p with write_flag=00; the memory registers lines at the end of this cycle. Next state EVAL.
- EVAL:
  - Hold pixel p, drive write_flag=01 and new_pixel_value=rule(p).
  - p<63: pixel<=p+1, next state READ. p==63: next state COMMIT.
- COMMIT: write_flag=10 for exactly one cycle; pixel stays 63. Next state DONE.
- DONE: gen_done=1, gen_count++, pixel<=0. Next state IDLE.
- Timing from the start edge (cycle 0):
  - pixel p READ in cycle 2p+1, EVAL in cycle 2p+2.
  - COMMIT in cycle 129, DONE in cycle 130.
  - busy=1 for cycles 1..130.
- Under continuous run, gen_done spacing is 130+GEN_PERIOD cycles.
- step while busy: ignored, not queued. run deasserted while busy: the current generation completes.
- Rule:
  - A cell is alive iff its byte != 0.
  - Neighbours: cols c-1, c, c+1 (mod 8) of previous_line and next_line, plus cols c-1 and c+1 of current_line. Row wrap is provided by the memory.
  - n = 4-bit neighbour count, 0..8.
  - Next state alive iff (alive & (n==2 | n==3)) | (!alive & n==3).
- Output decode: write_flag and busy are Moore-decoded from state. new_pixel_value is combinational in EVAL and forced to 8'h00 in all other states.

Decomposition:
- Package life_pkg: state enum (IDLE, READ, EVAL, COMMIT, DONE); write-flag constants WF_NONE=2'b00, WF_WRITE=2'b01, WF_REPLACE=2'b10; CELL_DEAD=8'h00.
- Sub-module life_rule (combinational). Inputs: three 64-bit lines, col[2:0], ALIVE_VAL parameter. Output: next byte. Contains the column wrap, neighbour count and rule.

Test Plan:
- Blinker: cells at pixels 25,26,27 = FF, step -> WRITE FF at pixels 18,26,34 and 00 elsewhere; REPLACE in cycle 129; gen_done in cycle 130; gen_count=1. Second step restores 25,26,27.
- Block still life at pixels 9,10,17,18 -> after step all 64 written values equal the input grid.
- Toroidal wrap: corners 0,7,56,63 alive -> all four remain alive (count 3 each via wrap); every other cell 00.
- Auto-run, GEN_PERIOD=4, empty grid, run=1 -> gen_done every 134 cycles; gen_count 1,2,3; all writes 00. Drop run -> no further starts.
- Reset pulse in cycle 60 of a blinker generation -> outputs at reset values at once, no REPLACE seen. Next step yields the correct blinker result from the original grid.
- step held high in cycles 0..5 plus run=1 with tick at expiry -> exactly one generation, gen_count increments by 1.
